// File: rtl/mem_bist_pkg.sv
// mem_bist_pkg: shared types and helpers for the memory BIST engine.
//   bist_state_t  - march FSM states
//   bist_mode_t   - data pattern selector
//   MEM_SIZE_WORD - word access encoding on the mem_top bus
//   bist_pattern  - un-inverted expected data for one access
package mem_bist_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WADDR,
    ST_WDATA,
    ST_RADDR,
    ST_RDATA
  } bist_state_t;

  typedef enum logic [1:0] {
    MODE_FIXED,
    MODE_ADDR,
    MODE_INV_ADDR,
    MODE_WALK1
  } bist_mode_t;

  localparam logic [1:0] MEM_SIZE_WORD = 2'b10;

  function automatic logic [31:0] bist_pattern(input bist_mode_t mode,
                                               input logic [4:0] idx_lo,
                                               input logic [31:0] addr,
                                               input logic [31:0] fixed);
    logic [31:0] r;
    case (mode)
      MODE_FIXED:    r = fixed;
      MODE_ADDR:     r = addr;
      MODE_INV_ADDR: r = ~addr;
      MODE_WALK1:    r = 32'h1 << idx_lo;
      default:       r = fixed;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/mem_bist_pattern_gen.sv
// mem_bist_pattern_gen: combinational expected-data generator.
// Ports:
//   mode   in 2  - data pattern (bist_mode_t encoding)
//   index  in 5  - low bits of the word index (walking-one position)
//   addr   in 32 - byte address of the access
//   invert in 1  - invert the pattern (odd passes)
//   data   out 32 - expected data
module mem_bist_pattern_gen
  import mem_bist_pkg::*;
#(
  parameter logic [31:0] FIXED_PATTERN = 32'hDEAD_BEEF
) (
  input  logic [1:0]  mode,
  input  logic [4:0]  index,
  input  logic [31:0] addr,
  input  logic        invert,
  output logic [31:0] data
);

  assign data = bist_pattern(bist_mode_t'(mode), index, addr, FIXED_PATTERN) ^ {32{invert}};

endmodule

// File: rtl/mem_bist.sv
// mem_bist: write-all / read-all march BIST over a programmable word range.
// Ports:
//   clock, reset                    - clock, synchronous active-high reset
//   start, abort                    - run control
//   mode, start_addr, word_count,
//   num_passes                      - run configuration, latched on start
//   bus_addr/wdata/size/write       - memory request
//   bus_rdata, bus_pause            - memory response and stall
//   busy, done, pass, aborted       - status (done/pass/aborted sticky)
//   err_count                       - saturating mismatch count
//   fail_addr/exp/act               - first mismatch of the run
// Build option: define MEM_BIST_FAIL_CAPTURE_EN to build the fail capture
// registers; otherwise fail_* read as 0.
module mem_bist
  import mem_bist_pkg::*;
#(
  parameter int          CNT_W         = 16,
  parameter int          PASS_W        = 4,
  parameter logic [31:0] FIXED_PATTERN = 32'hDEAD_BEEF
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              start,
  input  logic              abort,
  input  logic [1:0]        mode,
  input  logic [31:0]       start_addr,
  input  logic [CNT_W-1:0]  word_count,
  input  logic [PASS_W-1:0] num_passes,
  output logic [31:0]       bus_addr,
  output logic [31:0]       bus_wdata,
  output logic [1:0]        bus_size,
  output logic              bus_write,
  input  logic [31:0]       bus_rdata,
  input  logic              bus_pause,
  output logic              busy,
  output logic              done,
  output logic              pass,
  output logic              aborted,
  output logic [CNT_W-1:0]  err_count,
  output logic [31:0]       fail_addr,
  output logic [31:0]       fail_exp,
  output logic [31:0]       fail_act
);

  localparam logic [CNT_W-1:0]  CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [PASS_W-1:0] PASS_ONE = {{(PASS_W-1){1'b0}}, 1'b1};

  bist_state_t       state_q, state_d;
  bist_mode_t        mode_q, mode_d;
  logic [31:0]       base_q, base_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic [CNT_W-1:0]  index_q, index_d;
  logic [PASS_W-1:0] last_pass_q, last_pass_d;
  logic [PASS_W-1:0] pass_idx_q, pass_idx_d;
  logic              zero_pend_q, zero_pend_d;
  logic              done_q, done_d;
  logic              pass_q, pass_d;
  logic              aborted_q, aborted_d;
  logic [CNT_W-1:0]  err_q, err_d;

  logic [31:0] cur_addr;
  logic [31:0] exp_data;
  logic        last_word;
  logic        mismatch;

  assign cur_addr  = base_q + (32'(index_q) << 2);
  assign last_word = (index_q == count_q - CNT_ONE);
  assign mismatch  = (bus_rdata != exp_data);

  mem_bist_pattern_gen #(
    .FIXED_PATTERN (FIXED_PATTERN)
  ) u_pattern_gen (
    .mode   (mode_q),
    .index  (index_q[4:0]),
    .addr   (cur_addr),
    .invert (pass_idx_q[0]),
    .data   (exp_data)
  );

  always_comb begin
    state_d     = state_q;
    mode_d      = mode_q;
    base_d      = base_q;
    count_d     = count_q;
    index_d     = index_q;
    last_pass_d = last_pass_q;
    pass_idx_d  = pass_idx_q;
    zero_pend_d = zero_pend_q;
    done_d      = done_q;
    pass_d      = pass_q;
    aborted_d   = aborted_q;
    err_d       = err_q;
    if (!bus_pause) begin
      case (state_q)
        ST_IDLE: begin
          // A zero-length run completes one cycle after it is accepted.
          if (zero_pend_q) begin
            zero_pend_d = 1'b0;
            done_d      = 1'b1;
            pass_d      = 1'b1;
          end
          if (start) begin
            mode_d      = bist_mode_t'(mode);
            base_d      = start_addr & ~32'h3;
            count_d     = word_count;
            last_pass_d = (num_passes == '0) ? '0 : num_passes - PASS_ONE;
            index_d     = '0;
            pass_idx_d  = '0;
            done_d      = 1'b0;
            pass_d      = 1'b0;
            aborted_d   = 1'b0;
            err_d       = '0;
            if (word_count == '0) zero_pend_d = 1'b1;
            else                  state_d     = ST_WADDR;
          end
        end
        ST_WADDR: state_d = ST_WDATA;
        ST_WDATA: begin
          if (abort) begin
            state_d   = ST_IDLE;
            done_d    = 1'b1;
            aborted_d = 1'b1;
            pass_d    = 1'b0;
          end else if (last_word) begin
            state_d = ST_RADDR;
            index_d = '0;
          end else begin
            state_d = ST_WADDR;
            index_d = index_q + CNT_ONE;
          end
        end
        ST_RADDR: state_d = ST_RDATA;
        ST_RDATA: begin
          if (mismatch && !(&err_q)) err_d = err_q + CNT_ONE;
          if (abort) begin
            state_d   = ST_IDLE;
            done_d    = 1'b1;
            aborted_d = 1'b1;
            pass_d    = 1'b0;
          end else if (last_word) begin
            index_d = '0;
            if (pass_idx_q == last_pass_q) begin
              state_d = ST_IDLE;
              done_d  = 1'b1;
              pass_d  = (err_d == '0);
            end else begin
              state_d    = ST_WADDR;
              pass_idx_d = pass_idx_q + PASS_ONE;
            end
          end else begin
            state_d = ST_RADDR;
            index_d = index_q + CNT_ONE;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      mode_q      <= MODE_FIXED;
      base_q      <= '0;
      count_q     <= '0;
      index_q     <= '0;
      last_pass_q <= '0;
      pass_idx_q  <= '0;
      zero_pend_q <= 1'b0;
      done_q      <= 1'b0;
      pass_q      <= 1'b0;
      aborted_q   <= 1'b0;
      err_q       <= '0;
    end else begin
      state_q     <= state_d;
      mode_q      <= mode_d;
      base_q      <= base_d;
      count_q     <= count_d;
      index_q     <= index_d;
      last_pass_q <= last_pass_d;
      pass_idx_q  <= pass_idx_d;
      zero_pend_q <= zero_pend_d;
      done_q      <= done_d;
      pass_q      <= pass_d;
      aborted_q   <= aborted_d;
      err_q       <= err_d;
    end
  end

`ifdef MEM_BIST_FAIL_CAPTURE_EN
  logic [31:0] fail_addr_q, fail_exp_q, fail_act_q;
  logic        start_acc;
  logic        fail_load;

  assign start_acc = (state_q == ST_IDLE) && !bus_pause && start;
  // err_count is still zero only until the first mismatch of the run.
  assign fail_load = (state_q == ST_RDATA) && !bus_pause && mismatch && (err_q == '0);

  always_ff @(posedge clock) begin
    if (reset || start_acc) begin
      fail_addr_q <= '0;
      fail_exp_q  <= '0;
      fail_act_q  <= '0;
    end else if (fail_load) begin
      fail_addr_q <= cur_addr;
      fail_exp_q  <= exp_data;
      fail_act_q  <= bus_rdata;
    end
  end

  assign fail_addr = fail_addr_q;
  assign fail_exp  = fail_exp_q;
  assign fail_act  = fail_act_q;
`else
  assign fail_addr = '0;
  assign fail_exp  = '0;
  assign fail_act  = '0;
`endif

  assign busy      = (state_q != ST_IDLE);
  assign done      = done_q;
  assign pass      = pass_q;
  assign aborted   = aborted_q;
  assign err_count = err_q;
  assign bus_write = (state_q == ST_WADDR);
  assign bus_size  = MEM_SIZE_WORD;
  assign bus_addr  = busy ? cur_addr : '0;
  assign bus_wdata = busy ? exp_data : '0;

endmodule
